raven_sram_rmw_bridge: RTL and testbench

//   Sits between the raven_soc native memory bus and the sram_32_1024_freepdk45 macro.

---
 rtl/raven_sram_rmw_bridge_if.sv | 19 +
 rtl/raven_sram_rmw_bridge.sv | 150 +++++++++++++++
 tb/tb_raven_sram_rmw_bridge.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/raven_sram_rmw_bridge_if.sv
// Native raven_soc memory bus: valid/ready request with byte strobes.
interface raven_sram_rmw_bridge_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/raven_sram_rmw_bridge.sv
// Bridge from the raven_soc memory bus to a single-port SRAM macro without
// byte masks. Partial writes run as read-modify-write. Every output is a
// register; the combinational process computes the values for the next cycle.
module raven_sram_rmw_bridge #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                      pll_clk,
    input  logic                      reset,
    raven_sram_rmw_bridge_if.slave    mem,
    output logic                      ram_csb,
    output logic                      ram_wenb,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [31:0]               ram_wdata,
    input  logic [31:0]               ram_rdata,
    output logic                      busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        DONE
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    state_t              state_q, state_d;
    logic [1:0]          wait_cnt_q, wait_cnt_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                csb_q, csb_d;
    logic                wenb_q, wenb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         ram_wdata_q, ram_wdata_d;
    logic                busy_q;

    // Byte-lane and upper address bits are intentionally not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem.mem_addr[31:ADDR_W+2], mem.mem_addr[1:0]};

    // Next-state and next-output decode; the SRAM read word is the buffer,
    // folded straight into mem_rdata (reads) or the merged write word (RMW).
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch.
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        csb_d       = 1'b1;
        wenb_d      = 1'b1;
        addr_d      = addr_q;
        ram_wdata_d = ram_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (mem.mem_valid) begin
                    wstrb_d = mem.mem_wstrb;
                    wdata_d = mem.mem_wdata;
                    addr_d  = mem.mem_addr[ADDR_W+1:2];
                    csb_d   = 1'b0;
                    if (mem.mem_wstrb == 4'hF) begin
                        state_d     = WR_ISSUE;
                        wenb_d      = 1'b0;
                        ram_wdata_d = mem.mem_wdata;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                state_d    = RD_WAIT;
                wait_cnt_d = 2'd0;
            end
            RD_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    if (wstrb_q == 4'h0) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        rdata_d = ram_rdata;
                    end else begin
                        state_d = WR_ISSUE;
                        csb_d   = 1'b0;
                        wenb_d  = 1'b0;
                        for (int b = 0; b < 4; b++) begin
                            ram_wdata_d[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8]
                                                               : ram_rdata[8*b +: 8];
                        end
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            WR_ISSUE: begin
                state_d = DONE;
                ready_d = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset forces the SRAM deselected at once.
    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 2'd0;
            wstrb_q     <= 4'h0;
            wdata_q     <= 32'h0;
            ready_q     <= 1'b0;
            rdata_q     <= 32'h0;
            csb_q       <= 1'b1;
            wenb_q      <= 1'b1;
            addr_q      <= '0;
            ram_wdata_q <= 32'h0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            csb_q       <= csb_d;
            wenb_q      <= wenb_d;
            addr_q      <= addr_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign mem.mem_ready = ready_q;
    assign mem.mem_rdata = rdata_q;
    assign ram_csb       = csb_q;
    assign ram_wenb      = wenb_q;
    assign ram_addr      = addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_raven_sram_rmw_bridge.sv
// Bench for raven_sram_rmw_bridge: two instances (READ_LATENCY 1 and 3), each
// with a behavioural SRAM, checked against a word-array reference model.
module tb_raven_sram_rmw_bridge;

    localparam int NI = 2;

    logic pll_clk = 1'b0;
    logic reset;
    logic init_mem;

    always #5 pll_clk = ~pll_clk;

    logic        valid_d [NI];
    logic [31:0] addr_d  [NI];
    logic [3:0]  strb_d  [NI];
    logic [31:0] wdata_d [NI];

    logic        ready_o     [NI];
    logic [31:0] rdata_o     [NI];
    logic        csb_o       [NI];
    logic        wenb_o      [NI];
    logic [9:0]  ram_addr_o  [NI];
    logic [31:0] ram_wdata_o [NI];
    logic        busy_o      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        raven_sram_rmw_bridge_if bus ();
        logic        csb, wenb, busy;
        logic [9:0]  ram_addr;
        logic [31:0] ram_wdata, ram_rdata;
        logic [31:0] sram [1024];
        logic [31:0] pipe [LAT];

        assign bus.mem_valid = valid_d[g];
        assign bus.mem_addr  = addr_d[g];
        assign bus.mem_wstrb = strb_d[g];
        assign bus.mem_wdata = wdata_d[g];

        assign ready_o[g]     = bus.mem_ready;
        assign rdata_o[g]     = bus.mem_rdata;
        assign csb_o[g]       = csb;
        assign wenb_o[g]      = wenb;
        assign ram_addr_o[g]  = ram_addr;
        assign ram_wdata_o[g] = ram_wdata;
        assign busy_o[g]      = busy;

        raven_sram_rmw_bridge #(.ADDR_W(10), .READ_LATENCY(LAT)) dut (
            .pll_clk   (pll_clk),
            .reset     (reset),
            .mem       (bus),
            .ram_csb   (csb),
            .ram_wenb  (wenb),
            .ram_addr  (ram_addr),
            .ram_wdata (ram_wdata),
            .ram_rdata (ram_rdata),
            .busy      (busy)
        );

        // SRAM macro: read word appears LAT cycles after the capture edge;
        // non-read cycles push random garbage so a mistimed capture shows up.
        assign ram_rdata = pipe[LAT-1];
        always @(posedge pll_clk) begin
            if (init_mem) begin
                for (int k = 0; k < 1024; k++) sram[k] <= 32'h0;
            end else if (!csb && !wenb) begin
                sram[ram_addr] <= ram_wdata;
            end
            pipe[0] <= (!csb && wenb) ? sram[ram_addr] : $urandom;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    int checks;
    int failures;

    logic [31:0] model   [NI][1024];
    logic [31:0] last_rd [NI];
    int          csb_total [NI];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Per-cycle SRAM pin monitor: write enable only with chip select, and
    // a running count of chip-select cycles per instance.
    always @(negedge pll_clk) begin
        if (!reset) begin
            for (int i = 0; i < NI; i++) begin
                if (!wenb_o[i]) check("wenb_without_csb", 32'(csb_o[i]), 32'h0);
                if (!csb_o[i]) csb_total[i]++;
            end
        end
    end

    task automatic reset_vals(input int i);
        check("rst_ready", 32'(ready_o[i]), 32'h0);
        check("rst_rdata", rdata_o[i], 32'h0);
        check("rst_csb", 32'(csb_o[i]), 32'h1);
        check("rst_wenb", 32'(wenb_o[i]), 32'h1);
        check("rst_addr", 32'(ram_addr_o[i]), 32'h0);
        check("rst_wdata", ram_wdata_o[i], 32'h0);
        check("rst_busy", 32'(busy_o[i]), 32'h0);
    endtask

    // One bus transaction, starting and ending at a falling edge. valid is
    // left high on return, so it is held through DONE unless dropped.
    task automatic xact(input int i, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit scramble, output logic [31:0] rd);
        int          n, exp_lat, exp_csb, c0, lat;
        bit          got;
        logic [9:0]  w;
        logic [31:0] exp_rd;

        for (int j = 0; j < NI; j++) if (j != i) valid_d[j] = 1'b0;
        valid_d[i] = 1'b1;
        addr_d[i]  = a;
        strb_d[i]  = s;
        wdata_d[i] = d;
        if (busy_o[i]) begin
            @(posedge pll_clk);
            @(negedge pll_clk);
            check("idle_bubble", 32'(busy_o[i]), 32'h0);
            check("ready_pulse", 32'(ready_o[i]), 32'h0);
        end

        lat     = lat_of(i);
        w       = a[11:2];
        exp_lat = (s == 4'hF) ? 2 : (s == 4'h0) ? 2 + lat : 3 + lat;
        exp_csb = (s == 4'hF || s == 4'h0) ? 1 : 2;
        if (s == 4'h0) begin
            exp_rd     = model[i][w];
            last_rd[i] = exp_rd;
        end else begin
            exp_rd = last_rd[i];
            for (int b = 0; b < 4; b++)
                if (s[b]) model[i][w][8*b +: 8] = d[8*b +: 8];
        end
        c0 = csb_total[i];

        @(posedge pll_clk);
        n   = 0;
        got = 1'b0;
        while (!got && n < 16) begin
            @(negedge pll_clk);
            n++;
            if (ready_o[i]) begin
                got = 1'b1;
            end else if (scramble) begin
                valid_d[i] = 1'($urandom_range(0, 1));
                addr_d[i]  = $urandom;
                strb_d[i]  = 4'($urandom);
                wdata_d[i] = $urandom;
            end
        end
        check("latency", 32'(n), 32'(exp_lat));
        check("rdata", rdata_o[i], exp_rd);
        check("csb_pulses", 32'(csb_total[i] - c0), 32'(exp_csb));
        rd = rdata_o[i];
    endtask

    task automatic idle(input int cyc);
        for (int j = 0; j < NI; j++) valid_d[j] = 1'b0;
        repeat (cyc) begin
            @(posedge pll_clk);
            @(negedge pll_clk);
        end
        if (cyc >= 1)
            for (int j = 0; j < NI; j++) check("idle_busy", 32'(busy_o[j]), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, r;
        int          i, kind;
        logic [3:0]  s;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        init_mem = 1'b1;
        for (int j = 0; j < NI; j++) begin
            valid_d[j]   = 1'b0;
            addr_d[j]    = 32'h0;
            strb_d[j]    = 4'h0;
            wdata_d[j]   = 32'h0;
            last_rd[j]   = 32'h0;
            csb_total[j] = 0;
            for (int k = 0; k < 1024; k++) model[j][k] = 32'h0;
        end
        repeat (3) @(negedge pll_clk);
        init_mem = 1'b0;
        for (int j = 0; j < NI; j++) reset_vals(j);
        reset = 1'b0;

        // Full write then read, L=1.
        xact(0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, rd);
        xact(0, 32'h10, 4'h0, 32'h0, 1'b0, rd);
        check("t2_read", rd, 32'hDEADBEEF);

        // Read-modify-write, back to back with the previous accesses.
        xact(0, 32'h20, 4'hF, 32'h11223344, 1'b0, rd);
        xact(0, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0, rd);
        xact(0, 32'h20, 4'h0, 32'h0, 1'b0, rd);
        check("t3_rmw", rd, 32'h11BB33DD);
        idle(2);

        // Address wrap with L=3.
        xact(1, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, rd);
        xact(1, 32'h1000, 4'h0, 32'h0, 1'b0, rd);
        check("t5_wrap", rd, 32'hCAFEF00D);
        idle(1);

        // Reset in the middle of RD_WAIT.
        valid_d[1] = 1'b1;
        addr_d[1]  = 32'h1000;
        strb_d[1]  = 4'h0;
        @(posedge pll_clk);
        @(negedge pll_clk);
        check("t1_issue_csb", 32'(csb_o[1]), 32'h0);
        @(posedge pll_clk);
        @(negedge pll_clk);
        check("t1_wait_busy", 32'(busy_o[1]), 32'h1);
        reset = 1'b1;
        #1;
        reset_vals(1);
        reset_vals(0);
        valid_d[1] = 1'b0;
        repeat (4) begin
            @(posedge pll_clk);
            @(negedge pll_clk);
            check("t1_no_ready", 32'(ready_o[1]), 32'h0);
        end
        reset = 1'b0;
        for (int j = 0; j < NI; j++) last_rd[j] = 32'h0;
        xact(1, 32'h0, 4'h0, 32'h0, 1'b0, rd);
        check("t1_recover", rd, 32'hCAFEF00D);

        // Randomized mixed traffic.
        for (int k = 0; k < 10000; k++) begin
            i    = $urandom_range(0, NI - 1);
            r    = $urandom;
            r    = (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            kind = $urandom_range(0, 2);
            s    = (kind == 0) ? 4'h0 : (kind == 1) ? 4'hF : 4'($urandom_range(1, 14));
            xact(i, r, s, $urandom, 1'($urandom_range(0, 1)), rd);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
